// File: rtl/hermes_input_buffer_pkg.sv
// Shared defaults and FSM state encoding for the Hermes per-port input buffer.
package hermes_input_buffer_pkg;

  localparam int TAM_FLIT_DEF   = 16;
  localparam int TAM_BUFFER_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_HDR  = 3'd2,
    S_SIZE = 3'd3,
    S_PAY  = 3'd4,
    S_END  = 3'd5
  } state_t;

endpackage

// File: rtl/hermes_fifo.sv
// Circular flit buffer: power-of-two depth, occupancy count, head always visible on rd_data.
module hermes_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_req,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;

  // A push into a full buffer is dropped rather than overwriting the oldest flit.
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push    = push_req && !full;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + (PW+1)'(1);
      end else if (!push && pop) begin
        cnt <= cnt - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes router input port: buffers flits, requests routing for each header, and streams
// header, size and payload to the crossbar once the route is granted.
module hermes_input_buffer
  import hermes_input_buffer_pkg::*;
#(
  parameter int TAM_FLIT   = TAM_FLIT_DEF,
  parameter int TAM_BUFFER = TAM_BUFFER_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_rx,
  input  logic [TAM_FLIT-1:0] i_data,
  output logic                o_credit,
  output logic                o_h,
  input  logic                i_ack_h,
  output logic                o_data_av,
  output logic [TAM_FLIT-1:0] o_data,
  input  logic                i_data_ack,
  output logic                o_sender
);

  logic [$clog2(TAM_BUFFER):0] cnt;
  logic                        full;
  logic                        empty;
  logic                        pop;
  logic [TAM_FLIT-1:0]         rem;
  state_t                      state;
  state_t                      next_state;

  assign pop      = o_data_av && i_data_ack;
  assign o_credit = !full;

  hermes_fifo #(
    .WIDTH (TAM_FLIT),
    .DEPTH (TAM_BUFFER)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_req (i_rx),
    .pop      (pop),
    .wr_data  (i_data),
    .rd_data  (o_data),
    .cnt      (cnt),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A zero size flit skips the payload phase entirely.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (!empty) next_state = S_WAIT;
      S_WAIT: if (i_ack_h) next_state = S_HDR;
      S_HDR:  if (pop) next_state = S_SIZE;
      S_SIZE: if (pop) next_state = (o_data == '0) ? S_END : S_PAY;
      S_PAY:  if (pop && rem == TAM_FLIT'(1)) next_state = S_END;
      S_END:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_h       = 1'b0;
    o_data_av = 1'b0;
    case (state)
      S_WAIT:              o_h       = 1'b1;
      S_HDR, S_SIZE, S_PAY: o_data_av = !empty;
      default: ;
    endcase
  end

  // The connection is held from the routing grant until the last flit leaves.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_sender <= 1'b0;
      rem      <= '0;
    end else begin
      if (state == S_WAIT && i_ack_h) begin
        o_sender <= 1'b1;
      end else if (next_state == S_END && state != S_END) begin
        o_sender <= 1'b0;
      end
      if (state == S_SIZE && pop) begin
        rem <= o_data;
      end else if (state == S_PAY && pop) begin
        rem <= rem - TAM_FLIT'(1);
      end
    end
  end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Directed testbench for hermes_input_buffer: framing, flow control, wrap, reset and packet gaps.
module tb_hermes_input_buffer;

  logic        clock;
  logic        reset;
  logic        i_rx;
  logic [15:0] i_data;
  logic        o_credit;
  logic        o_h;
  logic        i_ack_h;
  logic        o_data_av;
  logic [15:0] o_data;
  logic        i_data_ack;
  logic        o_sender;

  int tests_run;
  int tests_failed;

  hermes_input_buffer #(
    .TAM_FLIT   (16),
    .TAM_BUFFER (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_rx       (i_rx),
    .i_data     (i_data),
    .o_credit   (o_credit),
    .o_h        (o_h),
    .i_ack_h    (i_ack_h),
    .o_data_av  (o_data_av),
    .o_data     (o_data),
    .i_data_ack (i_data_ack),
    .o_sender   (o_sender)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    i_rx       = 1'b0;
    i_data     = '0;
    i_ack_h    = 1'b0;
    i_data_ack = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; i_rx = 1'b0; i_data = '0; i_ack_h = 1'b0; i_data_ack = 1'b0;
    #1;
    tests_run++; if (o_h !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_o_h: got %b want 0", o_h); end
    tests_run++; if (o_data_av !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_data_av: got %b want 0", o_data_av); end
    tests_run++; if (o_sender !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sender: got %b want 0", o_sender); end
    tests_run++; if (o_credit !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_credit: got %b want 1", o_credit); end
    do_reset();
  endtask

  task automatic test_basic_packet();
    do_reset();
    i_rx = 1'b1; i_data = 16'h0012; tick();
    tests_run++; if (o_h !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_h_early: got %b want 0", o_h); end
    i_data = 16'd2; tick();
    tests_run++; if (o_h !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_h_raised: got %b want 1", o_h); end
    i_data = 16'hA5A5; tick();
    i_data = 16'h5A5A; i_ack_h = 1'b1; i_data_ack = 1'b1; tick();
    i_rx = 1'b0; i_ack_h = 1'b0;
    tests_run++; if (o_credit !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_credit_full: got %b want 0", o_credit); end
    tests_run++; if (o_sender !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_sender_set: got %b want 1", o_sender); end
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'h0012) begin tests_failed++; $display("[TB] FAIL basic_hdr: got av=%b data=%h want av=1 data=0012", o_data_av, o_data); end
    tick();
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'd2) begin tests_failed++; $display("[TB] FAIL basic_size: got av=%b data=%h want av=1 data=0002", o_data_av, o_data); end
    tests_run++; if (o_credit !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_credit_back: got %b want 1", o_credit); end
    tick();
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'hA5A5) begin tests_failed++; $display("[TB] FAIL basic_p0: got av=%b data=%h want av=1 data=a5a5", o_data_av, o_data); end
    tick();
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'h5A5A) begin tests_failed++; $display("[TB] FAIL basic_p1: got av=%b data=%h want av=1 data=5a5a", o_data_av, o_data); end
    tests_run++; if (o_sender !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_sender_hold: got %b want 1", o_sender); end
    tick();
    tests_run++; if (o_sender !== 1'b0 || o_data_av !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_end: got sender=%b av=%b want 0 0", o_sender, o_data_av); end
    tick();
    tests_run++; if (o_sender !== 1'b0 || o_data_av !== 1'b0 || o_h !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_idle: got sender=%b av=%b h=%b want 0 0 0", o_sender, o_data_av, o_h); end
    i_data_ack = 1'b0;
  endtask

  task automatic test_size_zero();
    do_reset();
    i_rx = 1'b1; i_data = 16'h0033; tick();
    i_data = 16'd0; tick();
    i_rx = 1'b0; i_ack_h = 1'b1; i_data_ack = 1'b1; tick();
    i_ack_h = 1'b0;
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'h0033) begin tests_failed++; $display("[TB] FAIL zero_hdr: got av=%b data=%h want av=1 data=0033", o_data_av, o_data); end
    tick();
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'd0) begin tests_failed++; $display("[TB] FAIL zero_size: got av=%b data=%h want av=1 data=0000", o_data_av, o_data); end
    tick();
    tests_run++; if (o_sender !== 1'b0 || o_data_av !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_end: got sender=%b av=%b want 0 0", o_sender, o_data_av); end
    tick();
    tests_run++; if (o_h !== 1'b0 || o_data_av !== 1'b0 || o_credit !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_idle: got h=%b av=%b credit=%b want 0 0 1", o_h, o_data_av, o_credit); end
    i_data_ack = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    i_rx = 1'b1; i_data = 16'h00F0; tick();
    i_data = 16'd2; tick();
    i_data = 16'h00F2; tick();
    i_data = 16'h00F3; tick();
    tests_run++; if (o_credit !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_credit_low: got %b want 0", o_credit); end
    tests_run++; if (o_h !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_h: got %b want 1", o_h); end
    i_data = 16'hBAD0; tick();
    tests_run++; if (o_credit !== 1'b0 || dut.u_fifo.cnt !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_drop: got credit=%b cnt=%0d want 0 4", o_credit, dut.u_fifo.cnt); end
    i_rx = 1'b0; i_ack_h = 1'b1; tick();
    i_ack_h = 1'b0;
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'h00F0) begin tests_failed++; $display("[TB] FAIL fill_hdr: got av=%b data=%h want av=1 data=00f0", o_data_av, o_data); end
    i_data_ack = 1'b1; tick();
    tests_run++; if (o_credit !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_credit_high: got %b want 1", o_credit); end
    tests_run++; if (o_data !== 16'd2) begin tests_failed++; $display("[TB] FAIL fill_size: got %h want 0002", o_data); end
    tick();
    tests_run++; if (o_data !== 16'h00F2) begin tests_failed++; $display("[TB] FAIL fill_p0: got %h want 00f2", o_data); end
    tick();
    tests_run++; if (o_data !== 16'h00F3) begin tests_failed++; $display("[TB] FAIL fill_p1: got %h want 00f3", o_data); end
    tick();
    tick();
    tick();
    tests_run++; if (o_h !== 1'b0 || o_data_av !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_no_fifth: got h=%b av=%b want 0 0", o_h, o_data_av); end
    i_data_ack = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_rx = 1'b1; i_data = 16'h0044; tick();
    i_data = 16'd3; tick();
    i_rx = 1'b0; i_ack_h = 1'b1; tick();
    i_ack_h = 1'b0; i_data_ack = 1'b1; i_rx = 1'b1; i_data = 16'h0A0A; tick();
    tests_run++; if (dut.u_fifo.cnt !== 3'd2 || o_data !== 16'd3) begin tests_failed++; $display("[TB] FAIL simul_1: got cnt=%0d data=%h want 2 0003", dut.u_fifo.cnt, o_data); end
    i_data = 16'h0B0B; tick();
    tests_run++; if (dut.u_fifo.cnt !== 3'd2 || o_data !== 16'h0A0A) begin tests_failed++; $display("[TB] FAIL simul_2: got cnt=%0d data=%h want 2 0a0a", dut.u_fifo.cnt, o_data); end
    i_data = 16'h0C0C; tick();
    tests_run++; if (dut.u_fifo.cnt !== 3'd2 || o_data !== 16'h0B0B) begin tests_failed++; $display("[TB] FAIL simul_3: got cnt=%0d data=%h want 2 0b0b", dut.u_fifo.cnt, o_data); end
    i_rx = 1'b0; tick();
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'h0C0C) begin tests_failed++; $display("[TB] FAIL simul_wrap: got av=%b data=%h want av=1 data=0c0c", o_data_av, o_data); end
    tick();
    tests_run++; if (o_sender !== 1'b0 || o_data_av !== 1'b0) begin tests_failed++; $display("[TB] FAIL simul_end: got sender=%b av=%b want 0 0", o_sender, o_data_av); end
    i_data_ack = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    i_rx = 1'b1; i_data = 16'h0055; tick();
    i_data = 16'd3; tick();
    i_data = 16'h1111; i_ack_h = 1'b1; tick();
    i_data = 16'h2222; i_ack_h = 1'b0; i_data_ack = 1'b1; tick();
    i_rx = 1'b0; tick();
    tests_run++; if (o_sender !== 1'b1 || o_data !== 16'h1111) begin tests_failed++; $display("[TB] FAIL midrst_pre: got sender=%b data=%h want 1 1111", o_sender, o_data); end
    reset = 1'b0;
    #1;
    tests_run++; if (o_data_av !== 1'b0 || o_h !== 1'b0 || o_sender !== 1'b0 || o_credit !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_out: got av=%b h=%b sender=%b credit=%b want 0 0 0 1", o_data_av, o_h, o_sender, o_credit); end
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    tests_run++; if (o_h !== 1'b0 || o_data_av !== 1'b0 || o_sender !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_discard: got h=%b av=%b sender=%b want 0 0 0", o_h, o_data_av, o_sender); end
    i_data_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_rx = 1'b1; i_data = 16'h00A0; tick();
    i_data = 16'd1; tick();
    i_data = 16'h0AA1; i_ack_h = 1'b1; tick();
    i_ack_h = 1'b0; i_data_ack = 1'b1; i_data = 16'h00B0; tick();
    i_data = 16'd1; tick();
    tests_run++; if (o_data !== 16'h0AA1) begin tests_failed++; $display("[TB] FAIL b2b_a_pay: got %h want 0aa1", o_data); end
    i_data = 16'h0BB1; tick();
    i_rx = 1'b0;
    tests_run++; if (o_sender !== 1'b0 || o_data_av !== 1'b0 || o_h !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_a_end: got sender=%b av=%b h=%b want 0 0 0", o_sender, o_data_av, o_h); end
    tick();
    tests_run++; if (o_h !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_gap: got h=%b want 0", o_h); end
    tick();
    tests_run++; if (o_h !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_b_h: got h=%b want 1", o_h); end
    i_ack_h = 1'b1; tick();
    i_ack_h = 1'b0;
    tests_run++; if (o_data_av !== 1'b1 || o_data !== 16'h00B0) begin tests_failed++; $display("[TB] FAIL b2b_b_hdr: got av=%b data=%h want av=1 data=00b0", o_data_av, o_data); end
    tick();
    tests_run++; if (o_data !== 16'd1) begin tests_failed++; $display("[TB] FAIL b2b_b_size: got %h want 0001", o_data); end
    tick();
    tests_run++; if (o_data !== 16'h0BB1) begin tests_failed++; $display("[TB] FAIL b2b_b_pay: got %h want 0bb1", o_data); end
    tick();
    tests_run++; if (o_sender !== 1'b0 || o_data_av !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_b_end: got sender=%b av=%b want 0 0", o_sender, o_data_av); end
    i_data_ack = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_packet();
    test_size_zero();
    test_fill();
    test_simultaneous();
    test_reset_mid_packet();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
